// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-entry output slot, stable memory handshake, branch flush.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        if_exc_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_addr, r_if_pc, r_if_inst;
  logic        r_req, r_flush, r_halt, r_if_valid, r_if_exc;

  logic        w_consume, w_free, w_tgt_mis, w_pc_mis;
  logic [31:0] w_tgt, w_pc_inc;

  assign w_consume = r_if_valid & ~stall_i;
  assign w_free    = ~r_if_valid | w_consume;
  assign w_pc_inc  = r_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_tgt     = branch_target_i;
  assign w_tgt_mis = |branch_target_i[1:0];
  assign w_pc_mis  = |r_pc[1:0];
`else
  assign w_tgt     = branch_target_i & 32'hFFFF_FFFC;
  assign w_tgt_mis = 1'b0;
  assign w_pc_mis  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_halt     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
      r_if_exc   <= 1'b0;
    end else begin
      if (w_consume) begin
        r_if_valid <= 1'b0;
        r_if_exc   <= 1'b0;
      end
      if (branch_flag_i) begin
        r_pc       <= w_tgt;
        r_halt     <= 1'b0;
        r_if_valid <= 1'b0;
        r_if_exc   <= 1'b0;
        if (r_state == S_REQ && !imem_ack_i) begin
          // in-flight request must finish unchanged; its word is dropped on return
          r_flush <= 1'b1;
        end else begin
          r_flush <= 1'b0;
          if (w_tgt_mis) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_halt     <= 1'b1;
            r_if_pc    <= w_tgt;
            r_if_inst  <= '0;
            r_if_valid <= 1'b1;
            r_if_exc   <= 1'b1;
          end else begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= w_tgt;
          end
        end
      end else begin
        case (r_state)
          S_IDLE: if (!r_halt) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          S_HOLD: if (w_free) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          S_REQ: if (imem_ack_i) begin
            if (r_flush) begin
              r_flush <= 1'b0;
              if (w_pc_mis) begin
                r_state    <= S_IDLE;
                r_req      <= 1'b0;
                r_halt     <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_inst  <= '0;
                r_if_valid <= 1'b1;
                r_if_exc   <= 1'b1;
              end else begin
                r_addr <= r_pc;
              end
            end else if (w_free) begin
              r_if_pc    <= r_pc;
              r_if_inst  <= imem_rdata_i;
              r_if_valid <= 1'b1;
              r_if_exc   <= 1'b0;
              r_pc       <= w_pc_inc;
              r_addr     <= w_pc_inc;
            end else begin
              // slot still stalled: drop this word, pc unchanged, refetch once it drains
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign if_pc_o     = r_if_pc;
  assign if_inst_o   = r_if_inst;
  assign if_valid_o  = r_if_valid;
  assign if_exc_o    = r_if_exc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable memory model, a slot monitor feeding an
// observed queue, and per-scenario tasks comparing it against pushed expectations.
module tb_fetch_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_valid_o, if_exc_o;

  logic        w2_req, w2_valid, w2_exc;
  logic [31:0] w2_addr, w2_pc, w2_inst;

  bit   tie_ack = 1'b0;
  int   lat = 0;
  int   wcnt = 0;
  bit   sb_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  item_t exp_q[$];
  item_t obs_q[$];

  always #5 clk = ~clk;

  assign imem_ack_i   = tie_ack | (imem_req_o && (wcnt >= lat));
  assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

  always @(posedge clk) wcnt <= (rst || !imem_req_o || imem_ack_i) ? 0 : wcnt + 1;

  // every slot handed downstream is recorded
  always @(negedge clk)
    if (sb_on && if_valid_o && !stall_i) obs_q.push_back(item_t'{if_pc_o, if_inst_o, if_exc_o});

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .if_valid_o(if_valid_o), .if_exc_o(if_exc_o)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .imem_req_o(w2_req), .imem_addr_o(w2_addr),
    .imem_ack_i(w2_req), .imem_rdata_i(w2_addr ^ 32'hA5A5_0000), .if_pc_o(w2_pc),
    .if_inst_o(w2_inst), .if_valid_o(w2_valid), .if_exc_o(w2_exc)
  );

  function automatic item_t mk(input logic [31:0] pc);
    return item_t'{pc, pc ^ 32'hA5A5_0000, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    tie_ack = 1'b0; lat = 0; sb_on = 1'b0;
    exp_q.delete(); obs_q.delete();
    step(); step();
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (obs_q.size() >= exp_q.size()) begin ok = 1'b1; break; end
      step();
    end
    sb_on = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(); rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", imem_addr_o); end
    n_cmp++; if (if_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", if_pc_o); end
    n_cmp++; if (if_inst_o !== 32'h0) begin n_bad++; $display("FAIL rst_inst got %h want 0", if_inst_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", if_valid_o); end
    n_cmp++; if (if_exc_o !== 1'b0) begin n_bad++; $display("FAIL rst_exc got %b want 0", if_exc_o); end
  endtask

  task automatic test_stream();
    bit ok;
    apply_reset(); tie_ack = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4)));
    sb_on = 1'b1; rst = 1'b0;
    step();
    n_cmp++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL stream_first got v=%b req=%b addr=%h want v=0 req=1 addr=0", if_valid_o, imem_req_o, imem_addr_o); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'(i * 4)) begin
        n_bad++; $display("FAIL stream_cyc%0d got v=%b pc=%h want v=1 pc=%h", i, if_valid_o, if_pc_o, 32'(i * 4)); end
    end
    drain(ok);
    tie_ack = 1'b0;
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stream_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stream_sb[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    exp_q.push_back(mk(0)); exp_q.push_back(mk(4)); exp_q.push_back(mk(8));
    exp_q.push_back(mk(12)); exp_q.push_back(mk(16));
    sb_on = 1'b1; rst = 1'b0;
    step(); step(); step(); step();
    n_cmp++; if (if_pc_o !== 32'h8 || if_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_pre got pc=%h v=%b want pc=8 v=1", if_pc_o, if_valid_o); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (if_pc_o !== 32'h8 || if_valid_o !== 1'b1 || imem_req_o !== 1'b0 || if_inst_o !== (32'h8 ^ 32'hA5A5_0000)) begin
        n_bad++; $display("FAIL stall_hold%0d got pc=%h v=%b req=%b inst=%h want pc=8 v=1 req=0", i, if_pc_o, if_valid_o, imem_req_o, if_inst_o); end
    end
    stall_i = 1'b0;
    step();
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_bad++; $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=c", imem_req_o, imem_addr_o); end
    step();
    n_cmp++; if (if_pc_o !== 32'hC || if_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_next got pc=%h v=%b want pc=c v=1", if_pc_o, if_valid_o); end
    drain(ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_sb[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_branch_flush(input bit twice);
    bit ok;
    logic [31:0] tgt;
    tgt = twice ? 32'h200 : 32'h100;
    apply_reset();
    exp_q.push_back(mk(0)); exp_q.push_back(mk(tgt)); exp_q.push_back(mk(tgt + 32'd4));
    sb_on = 1'b1; rst = 1'b0;
    step(); step();
    lat = 2; branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_flag_i = twice; branch_target_i = 32'h200;
    n_cmp++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_bad++; $display("FAIL br%0d_inflight got v=%b req=%b addr=%h want v=0 req=1 addr=4", twice, if_valid_o, imem_req_o, imem_addr_o); end
    step();
    branch_flag_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h4) begin
      n_bad++; $display("FAIL br%0d_wait got v=%b addr=%h want v=0 addr=4", twice, if_valid_o, imem_addr_o); end
    lat = 0;
    step();
    n_cmp++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== tgt) begin
      n_bad++; $display("FAIL br%0d_redirect got v=%b req=%b addr=%h want v=0 req=1 addr=%h", twice, if_valid_o, imem_req_o, imem_addr_o, tgt); end
    drain(ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL br%0d_cnt got %0d want %0d", twice, obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL br%0d_sb[%0d] got %h want %h", twice, i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_branch_stall();
    bit ok;
    apply_reset();
    exp_q.push_back(mk(0)); exp_q.push_back(mk(32'h40)); exp_q.push_back(mk(32'h44));
    sb_on = 1'b1; rst = 1'b0;
    step(); step(); step();
    stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h40;
    step();
    stall_i = 1'b0; branch_flag_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
      n_bad++; $display("FAIL brst_redirect got v=%b req=%b addr=%h want v=0 req=1 addr=40", if_valid_o, imem_req_o, imem_addr_o); end
    step();
    n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin n_bad++; $display("FAIL brst_first got v=%b pc=%h want v=1 pc=40", if_valid_o, if_pc_o); end
    drain(ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL brst_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL brst_sb[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_align();
    bit ok;
    apply_reset();
    exp_q.push_back(mk(0));
`ifdef FETCH_ALIGN_CHECK_EN
    exp_q.push_back(item_t'{32'h102, 32'h0, 1'b1});
`else
    exp_q.push_back(mk(32'h100)); exp_q.push_back(mk(32'h104));
`endif
    sb_on = 1'b1; rst = 1'b0;
    step(); step();
    branch_flag_i = 1'b1; branch_target_i = 32'h102;
    step();
    branch_flag_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    n_cmp++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_exc_o !== 1'b1 || if_pc_o !== 32'h102 || if_inst_o !== 32'h0) begin
      n_bad++; $display("FAIL align_exc got req=%b v=%b exc=%b pc=%h inst=%h want req=0 v=1 exc=1 pc=102 inst=0", imem_req_o, if_valid_o, if_exc_o, if_pc_o, if_inst_o); end
    step(); step();
    n_cmp++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL align_halt got req=%b v=%b want req=0 v=0", imem_req_o, if_valid_o); end
`else
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL align_force got req=%b addr=%h v=%b want req=1 addr=100 v=0", imem_req_o, imem_addr_o, if_valid_o); end
    step();
    n_cmp++; if (if_pc_o !== 32'h100 || if_exc_o !== 1'b0) begin n_bad++; $display("FAIL align_fetch got pc=%h exc=%b want pc=100 exc=0", if_pc_o, if_exc_o); end
`endif
    drain(ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL align_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL align_sb[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset(); lat = 3; rst = 1'b0;
    step();
    n_cmp++; if (imem_req_o !== 1'b1) begin n_bad++; $display("FAIL rmid_req got %b want 1", imem_req_o); end
    rst = 1'b1;
    step();
    n_cmp++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_drop got req=%b v=%b want 0 0", imem_req_o, if_valid_o); end
    rst = 1'b0; tie_ack = 1'b1;
    exp_q.push_back(mk(0)); exp_q.push_back(mk(4));
    sb_on = 1'b1;
    step();
    n_cmp++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL rmid_idle got v=%b req=%b addr=%h want v=0 req=1 addr=0", if_valid_o, imem_req_o, imem_addr_o); end
    step();
    n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin n_bad++; $display("FAIL rmid_first got v=%b pc=%h want v=1 pc=0", if_valid_o, if_pc_o); end
    drain(ok);
    tie_ack = 1'b0; lat = 0;
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rmid_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rmid_sb[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    apply_reset(); rst = 1'b0;
    step();
    n_cmp++; if (w2_req !== 1'b1 || w2_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req got req=%b addr=%h want 1 fffffffc", w2_req, w2_addr); end
    step();
    n_cmp++; if (w2_valid !== 1'b1 || w2_pc !== 32'hFFFF_FFFC || w2_addr !== 32'h0) begin
      n_bad++; $display("FAIL wrap_top got v=%b pc=%h addr=%h want v=1 pc=fffffffc addr=0", w2_valid, w2_pc, w2_addr); end
    step();
    n_cmp++; if (w2_valid !== 1'b1 || w2_pc !== 32'h0 || w2_inst !== 32'hA5A5_0000 || w2_exc !== 1'b0) begin
      n_bad++; $display("FAIL wrap_zero got v=%b pc=%h inst=%h exc=%b want v=1 pc=0 inst=a5a50000 exc=0", w2_valid, w2_pc, w2_inst, w2_exc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush(1'b0);
    test_branch_flush(1'b1);
    test_branch_stall();
    test_align();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall_i  in  1  downstream (IF/ID) not accepting; output slot must hold.
REQ-005 branch_flag_i  in  1  single-cycle redirect pulse from decode.
REQ-006 branch_target_i  in  32  redirect address, sampled when branch_flag_i=1.
REQ-007 imem_req_o  out  1  instruction memory request.
REQ-008 imem_addr_o  out  32  request address, word-aligned.
REQ-009 imem_ack_i  in  1  memory returns imem_rdata_i this cycle; may be high in the cycle req first rises.
REQ-010 imem_rdata_i  in  32  instruction word.
REQ-011 if_pc_o  out  32  PC of presented instruction, to IF/ID.
REQ-012 if_inst_o  out  32  presented instruction, to IF/ID.
REQ-013 if_valid_o  out  1  if_pc_o/if_inst_o hold a live instruction.
REQ-014 if_exc_o  out  1  misaligned-fetch flag, presented with the slot.

Function
REQ-015 States: IDLE (no request), REQ (imem_req_o=1, awaiting ack), HOLD (slot full, stalled, no request).
REQ-016 Slot consumed at an edge where if_valid_o=1 and stall_i=0; slot free when if_valid_o=0 or being consumed.
REQ-017 Request issued (REQ entered or kept) only when the slot is free or being consumed; otherwise HOLD.
REQ-018 In REQ, imem_req_o and imem_addr_o stay stable until imem_ack_i=1.
REQ-019 On ack (no flush): if_inst_o<=imem_rdata_i, if_pc_o<=pc, if_valid_o<=1, pc<=pc+4.
REQ-020 Zero-wait memory with stall_i=0 yields one instruction per cycle; fetch-to-valid latency 1 cycle after ack.
REQ-021 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 stall_i=1 with if_valid_o=1: if_pc_o/if_inst_o/if_valid_o/if_exc_o unchanged.
REQ-023 branch_flag_i=1: pc<=branch_target_i, if_valid_o<=0 next cycle; branch overrides stall_i.
REQ-024 Branch while REQ and no ack that cycle: request completes unchanged, returned word discarded (flush flag), next request to target.
REQ-025 Branch in same cycle as ack: ack data discarded; next request to target.
REQ-026 Second branch while flush pending: latest target wins; only one word discarded.
REQ-027 HOLD -> REQ when slot consumed; IDLE -> REQ first cycle after rst deasserts.

Reset
REQ-028 rst=1: pc<=RESET_PC, state IDLE, flush cleared, imem_req_o=0, imem_addr_o=0, if_pc_o=0, if_inst_o=0, if_valid_o=0, if_exc_o=0.
REQ-029 rst mid-request: request dropped immediately, late ack ignored while in IDLE.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: target with [1:0]!=0 issues no memory request; next cycle slot presents if_pc_o=target, if_inst_o=0, if_exc_o=1, if_valid_o=1; pc then held until next branch.
REQ-031 Macro undefined: target[1:0] forced to 2'b00, if_exc_o tied 0.

Verification
REQ-032 Reset then ack tied high, rdata=pc^32'hA5A5_0000 -> if_pc_o 0,4,8,... on consecutive cycles, if_valid_o=1 from cycle 2.
REQ-033 stall_i=1 for 3 cycles with slot holding pc 8 -> outputs frozen at pc 8, imem_req_o=0, resume with pc 12 next.
REQ-034 Branch to 32'h100 while ack delayed 2 cycles at addr 4 -> word at 4 never valid, next imem_addr_o=32'h100.
REQ-035 RESET_PC=32'hFFFF_FFFC, zero-wait -> if_pc_o FFFF_FFFC then 0000_0000.
REQ-036 Branch and stall_i same cycle -> if_valid_o=0 next cycle, fetch at target.
REQ-037 FETCH_ALIGN_CHECK_EN, branch to 32'h102 -> no imem_req_o, if_exc_o=1 with if_pc_o=32'h102; undefined -> fetch at 32'h100.
